// File: rtl/cpup_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, word width and the
// opcode bit that marks an attached immediate word.
package cpup_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned ATTACH_BIT = 1;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    WAIT_OP   = 3'd1,
    FETCH_IMM = 3'd2,
    WAIT_IMM  = 3'd3,
    EXEC      = 3'd4
  } fetch_state_e;

  function automatic logic has_imm(input logic [WORD_W-1:0] word);
    return word[ATTACH_BIT];
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer holding the opcode word fetched while the current
// instruction executes. Flush has priority over fill.
module fetch_prefetch_buf
  import cpup_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              fill_i,
  input  logic [WORD_W-1:0] fill_data_i,
  input  logic              take_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o
);

  logic              valid_q;
  logic [WORD_W-1:0] data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      data_q  <= fill_data_i;
    end else if (take_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches an opcode word and an optional immediate word
// over a req/ack memory port. Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer.
module fetch_unit
  import cpup_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic [15:0] pc
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  pc_inc_d;
  logic [15:0]  instr_q;
  logic [15:0]  imm_q;
  logic [15:0]  addr_q;
  logic         valid_q;
  logic         req_q;
  logic         discard_q;
  logic         buf_valid;
  logic [15:0]  buf_data;

  assign pc_inc_d = pc_q + 16'd1;

`ifdef FETCH_PREFETCH_EN
  logic buf_fill;
  logic buf_take;

  // A prefetch that returns together with a jump belongs to the old flow.
  assign buf_fill = (state_q == EXEC) && req_q && mem_ack && !discard_q && !pc_load;
  assign buf_take = (state_q == FETCH_OP) && buf_valid && !pc_load;

  fetch_prefetch_buf u_prefetch_buf (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (pc_load),
    .fill_i      (buf_fill),
    .fill_data_i (mem_data),
    .take_i      (buf_take),
    .valid_o     (buf_valid),
    .data_o      (buf_data)
  );
`else
  assign buf_valid = 1'b0;
  assign buf_data  = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      imm_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (pc_load) begin
            pc_q <= pc_load_val;
          end else if (buf_valid) begin
            instr_q <= buf_data;
            if (has_imm(buf_data)) begin
              state_q <= FETCH_IMM;
            end else begin
              valid_q <= 1'b1;
              state_q <= EXEC;
            end
          end else begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= WAIT_OP;
          end
        end

        WAIT_OP, WAIT_IMM: begin
          // A jump never cancels the bus cycle; it only marks the reply as stale.
          if (mem_ack) begin
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            if (pc_load) begin
              pc_q    <= pc_load_val;
              state_q <= FETCH_OP;
            end else if (discard_q) begin
              state_q <= FETCH_OP;
            end else begin
              pc_q <= pc_inc_d;
              if (state_q == WAIT_IMM) begin
                imm_q   <= mem_data;
                valid_q <= 1'b1;
                state_q <= EXEC;
              end else if (has_imm(mem_data)) begin
                instr_q <= mem_data;
                state_q <= FETCH_IMM;
              end else begin
                instr_q <= mem_data;
                valid_q <= 1'b1;
                state_q <= EXEC;
              end
            end
          end else if (pc_load) begin
            pc_q      <= pc_load_val;
            discard_q <= 1'b1;
          end
        end

        FETCH_IMM: begin
          if (pc_load) begin
            pc_q    <= pc_load_val;
            state_q <= FETCH_OP;
          end else begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= WAIT_IMM;
          end
        end

        EXEC: begin
`ifdef FETCH_PREFETCH_EN
          if (req_q && mem_ack) begin
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            if (!discard_q) pc_q <= pc_inc_d;
          end else if (req_q && pc_load) begin
            discard_q <= 1'b1;
          end else if (!req_q && !buf_valid && !pc_load && !exec_done) begin
            addr_q <= pc_q;
            req_q  <= 1'b1;
          end
`endif
          if (pc_load) pc_q <= pc_load_val;
          // An unanswered prefetch becomes the next opcode fetch.
          if (exec_done) begin
            valid_q <= 1'b0;
            state_q <= (req_q && !mem_ack) ? WAIT_OP : FETCH_OP;
          end
        end

        default: state_q <= FETCH_OP;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign mem_req     = req_q;
  assign instruction = instr_q;
  assign immediate   = imm_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule
